// File: rtl/clk_delay_line.sv
// -----------------------------------------------------------------------------
// clk_delay_line
//
// Run-time programmable cycle-delay line. It aligns D8M camera pixel and sync
// streams with each other and with downstream pipeline latency. A sample
// presented on one enabled iCLK cycle reappears on oDATA a programmable number
// of enabled cycles later. The storage is a circular buffer and the output is
// registered. A small two-state machine tracks the refill that follows a reset
// or a delay reload, so consumers know when oDATA can be trusted again.
//
// Parameters:
//   WIDTH          bits per sample
//   MAX_DEPTH      largest delay in enabled cycles (power of two, >= 2)
//   DEFAULT_DELAY  delay in effect after reset (0..MAX_DEPTH)
//
// Ports:
//   iCLK         in   clock, all logic on the rising edge
//   iRST_N       in   synchronous active-low reset
//   iEN          in   clock enable; the line advances only when 1
//   iDATA        in   [WIDTH-1:0] input sample
//   iDELAY       in   [clog2(MAX_DEPTH):0] requested delay, sampled on load
//   iDELAY_LOAD  in   single-cycle request to apply iDELAY
//   oDATA        out  [WIDTH-1:0] delayed sample (registered)
//   oVALID       out  oDATA is the sample from exactly oDELAY_CUR enabled
//                     cycles earlier
//   oBUSY        out  refill in progress after reset or reload
//   oDELAY_CUR   out  [clog2(MAX_DEPTH):0] delay currently in effect
//
// Handshake: there is no back-pressure. oVALID qualifies oDATA on every cycle.
// A consumer takes oDATA on a rising edge only when oVALID is 1. Both outputs
// hold their values while iEN is 0.
//
// Build option (macro CLK_DELAY_LINE_ZERO_FILL_EN):
//   defined   - oDATA is forced to 0 whenever the registered oVALID is 0
//   undefined - oDATA always carries the buffer read (or bypass) value, even
//               when invalid; oVALID and oBUSY timing does not change
// -----------------------------------------------------------------------------
module clk_delay_line #(
    parameter int WIDTH         = 10,
    parameter int MAX_DEPTH     = 16,
    parameter int DEFAULT_DELAY = 4
) (
    input  logic                         iCLK,
    input  logic                         iRST_N,
    input  logic                         iEN,
    input  logic [WIDTH-1:0]             iDATA,
    input  logic [$clog2(MAX_DEPTH):0]   iDELAY,
    input  logic                         iDELAY_LOAD,
    output logic [WIDTH-1:0]             oDATA,
    output logic                         oVALID,
    output logic                         oBUSY,
    output logic [$clog2(MAX_DEPTH):0]   oDELAY_CUR
);

    // AW addresses the buffer. DW can also hold the value MAX_DEPTH itself,
    // which both the delay and the fill count need.
    localparam int AW = $clog2(MAX_DEPTH);
    localparam int DW = AW + 1;

    localparam logic [DW-1:0] MAX_D = DW'(MAX_DEPTH);
    localparam logic [DW-1:0] DEF_D = DW'(DEFAULT_DELAY);

    typedef enum logic {
        ST_RELOAD = 1'b0,   // refilling; oBUSY asserted
        ST_RUN    = 1'b1    // steady state; output valid every enabled cycle
    } state_t;

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    state_t             state_q,     state_d;
    logic [AW-1:0]      wr_ptr_q,    wr_ptr_d;
    logic [DW-1:0]      fill_q,      fill_d;
    logic [DW-1:0]      cur_delay_q, cur_delay_d;
    logic [WIDTH-1:0]   data_q,      data_d;
    logic               valid_q,     valid_d;
    logic               busy_q,      busy_d;

    // Sample storage. It is not reset: fill_q guarantees that stale slots are
    // never flagged valid.
    logic [WIDTH-1:0]   mem_q [MAX_DEPTH];

    // ---------------------------------------------------------------------
    // Datapath helpers
    // ---------------------------------------------------------------------
    logic [AW-1:0]      rd_idx;
    logic [WIDTH-1:0]   rd_data;
    logic               fill_ok;
    logic [DW-1:0]      load_delay;
    logic               mem_we;

    // Modulo-MAX_DEPTH subtraction comes from truncation. For a delay of
    // MAX_DEPTH the low bits are zero, so the read hits the slot that this
    // same edge is about to overwrite. The memory is read before the write,
    // so that slot still holds the sample from MAX_DEPTH cycles ago.
    assign rd_idx     = wr_ptr_q - cur_delay_q[AW-1:0];

    // A zero delay bypasses the buffer, leaving a single register stage.
    assign rd_data    = (cur_delay_q == '0) ? iDATA : mem_q[rd_idx];

    // The fill count is taken before the increment. The slot being read
    // holds a post-load sample only once at least cur_delay samples have
    // been written since the last reset or reload.
    assign fill_ok    = (fill_q >= cur_delay_q);

    // Requests larger than the buffer saturate to the deepest usable delay.
    assign load_delay = (iDELAY > MAX_D) ? MAX_D : iDELAY;

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        fill_d      = fill_q;
        cur_delay_d = cur_delay_q;
        data_d      = data_q;
        valid_d     = valid_q;
        busy_d      = busy_q;
        mem_we      = 1'b0;

        // Writing and pointer movement depend only on the enable. A reload
        // on an enabled cycle still stores that sample, so the stream stays
        // continuous across the reload.
        if (iEN) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + AW'(1);
        end

        if (iDELAY_LOAD) begin
            // The reload wins over normal counting. The sample written on
            // this cycle is deliberately left out of fill.
            cur_delay_d = load_delay;
            fill_d      = '0;
            valid_d     = 1'b0;
            busy_d      = 1'b1;
            state_d     = ST_RELOAD;
            if (iEN) begin
                data_d = rd_data;
            end
        end else if (iEN) begin
            data_d  = rd_data;
            valid_d = fill_ok;
            fill_d  = (fill_q == MAX_D) ? fill_q : (fill_q + DW'(1));

            case (state_q)
                ST_RELOAD: begin
                    // Leave the refill on the same edge that oVALID rises.
                    if (fill_ok) begin
                        state_d = ST_RUN;
                        busy_d  = 1'b0;
                    end
                end
                ST_RUN: begin
                    state_d = ST_RUN;
                end
                default: begin
                    state_d = ST_RELOAD;
                    busy_d  = 1'b1;
                end
            endcase
        end

`ifdef CLK_DELAY_LINE_ZERO_FILL_EN
        // Consumers never see stale or pre-refill data.
        if (!valid_d) begin
            data_d = '0;
        end
`endif
    end

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            state_q     <= ST_RELOAD;
            wr_ptr_q    <= '0;
            fill_q      <= '0;
            cur_delay_q <= DEF_D;
            data_q      <= '0;
            valid_q     <= 1'b0;
            // With a zero default delay there is nothing to refill, so the
            // busy flag stays low. The next enabled cycle moves the FSM to
            // RUN without changing it.
            busy_q      <= (DEFAULT_DELAY != 0);
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            fill_q      <= fill_d;
            cur_delay_q <= cur_delay_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
        end
    end

    // The buffer write ignores reset. Its contents stay masked by fill_q
    // until they have been rewritten.
    always_ff @(posedge iCLK) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= iDATA;
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign oDATA      = data_q;
    assign oVALID     = valid_q;
    assign oBUSY      = busy_q;
    assign oDELAY_CUR = cur_delay_q;

endmodule
